// File: rtl/cpu_decode.sv
// cpu_decode: decode/register-read stage.
// Holds the 32x32 integer register file, accepts instructions from fetch over a
// valid/ready handshake, and presents instruction, PC and operands to execute
// through a one-entry pipeline register.
// Optional build macro: CPU_DECODE_BYPASS_EN
//   defined   -> same-cycle writeback is forwarded into captured operands and
//                into held operands while execute is stalled.
//   undefined -> reads see pre-write contents; the hazard unit must stall.
module cpu_decode #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_instr_i,
  input  logic [31:0] fetch_pc_i,
  input  logic        flush_i,
  input  logic        wb_en_i,
  input  logic [4:0]  wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        exec_valid_o,
  input  logic        exec_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o
);

  logic [31:0] regs [32];
  logic        wb_we;
  logic        capture;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_rd;
  logic [31:0] rs2_rd;

  // x0 is hard-wired, so a write to it is simply never performed.
  assign wb_we    = wb_en_i && (wb_addr_i != 5'd0);
  assign rs1_addr = fetch_instr_i[19:15];
  assign rs2_addr = fetch_instr_i[24:20];

  // Stage can accept when empty or when execute drains the held entry.
  assign fetch_ready_o = !reset && (!exec_valid_o || exec_ready_i);
  assign capture       = fetch_valid_i && fetch_ready_o && !flush_i;

  // Combinational register-file read of the incoming instruction's fields.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rs1_rd = (rs1_addr == 5'd0) ? 32'd0 : regs[rs1_addr];
    rs2_rd = (rs2_addr == 5'd0) ? 32'd0 : regs[rs2_addr];
`ifdef CPU_DECODE_BYPASS_EN
    if (wb_we && (wb_addr_i == rs1_addr)) rs1_rd = wb_data_i;
    if (wb_we && (wb_addr_i == rs2_addr)) rs2_rd = wb_data_i;
`endif
  end

  // Register file: cleared on reset, one write port from writeback.
  always_ff @(posedge clk) begin
    // NOTE: this array is reset explicitly because software relies on a zeroed
    // register file; that forces flops rather than a RAM macro.
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      // NOTE: sequential state uses non-blocking assignments only.
      regs[wb_addr_i] <= wb_data_i;
    end
  end

  // One-entry pipeline register toward execute: reset > flush > capture > drain > stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_valid_o <= 1'b0;
      instr_o      <= NOP_INSTR;
      pc_o         <= RESET_PC;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
    end else if (flush_i) begin
      exec_valid_o <= 1'b0;
      instr_o      <= NOP_INSTR;
    end else if (capture) begin
      exec_valid_o <= 1'b1;
      instr_o      <= fetch_instr_i;
      pc_o         <= fetch_pc_i;
      rs1_data_o   <= rs1_rd;
      rs2_data_o   <= rs2_rd;
    end else if (exec_ready_i) begin
      exec_valid_o <= 1'b0;
    end else if (exec_valid_o) begin
`ifdef CPU_DECODE_BYPASS_EN
      // Keep held operands coherent with writes landing during the stall.
      if (wb_we && (wb_addr_i == instr_o[19:15])) rs1_data_o <= wb_data_i;
      if (wb_we && (wb_addr_i == instr_o[24:20])) rs2_data_o <= wb_data_i;
`endif
    end
  end

endmodule

// File: tb/tb_cpu_decode.sv
// Directed self-checking bench for cpu_decode (works with and without
// CPU_DECODE_BYPASS_EN; expectations follow the macro).
module tb_cpu_decode;

  logic        clk;
  logic        reset;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_instr_i;
  logic [31:0] fetch_pc_i;
  logic        flush_i;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic        exec_valid_o;
  logic        exec_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] rs1_data_o;
  logic [31:0] rs2_data_o;

  int checks = 0;
  int errors = 0;

`ifdef CPU_DECODE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  cpu_decode dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o),
    .fetch_instr_i(fetch_instr_i),
    .fetch_pc_i   (fetch_pc_i),
    .flush_i      (flush_i),
    .wb_en_i      (wb_en_i),
    .wb_addr_i    (wb_addr_i),
    .wb_data_i    (wb_data_i),
    .exec_valid_o (exec_valid_o),
    .exec_ready_i (exec_ready_i),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .rs1_data_o   (rs1_data_o),
    .rs2_data_o   (rs2_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled and inputs driven 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_valid_i = 1'b0;
    fetch_instr_i = 32'h0;
    fetch_pc_i    = 32'h0;
    flush_i       = 1'b0;
    wb_en_i       = 1'b0;
    wb_addr_i     = 5'd0;
    wb_data_i     = 32'h0;
    exec_ready_i  = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    fetch_valid_i = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready_during got %b exp 0", fetch_ready_o); end
    checks++;
    if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", exec_valid_o); end
    checks++;
    if (instr_o !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr got %h exp 00000013", instr_o); end
    checks++;
    if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", pc_o); end
    checks++;
    if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++; $display("FAIL rst_operands got %h/%h exp 0/0", rs1_data_o, rs2_data_o);
    end
    reset = 1'b0;
    fetch_valid_i = 1'b0;
    #1;
    checks++;
    if (fetch_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready_after got %b exp 1", fetch_ready_o); end
    tick();
  endtask

  task automatic test_write_read();
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'hDEAD_BEEF;
    tick();
    wb_en_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0002_80B3; fetch_pc_i = 32'h100;
    tick();
    fetch_valid_i = 1'b0;
    checks++;
    if (exec_valid_o !== 1'b1) begin errors++; $display("FAIL wr_valid got %b exp 1", exec_valid_o); end
    checks++;
    if (rs1_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_rs1 got %h exp deadbeef", rs1_data_o); end
    checks++;
    if (rs2_data_o !== 32'h0) begin errors++; $display("FAIL wr_rs2 got %h exp 0", rs2_data_o); end
    checks++;
    if (pc_o !== 32'h100 || instr_o !== 32'h0002_80B3) begin
      errors++; $display("FAIL wr_pc_instr got %h/%h exp 100/000280b3", pc_o, instr_o);
    end
    tick();
    checks++;
    if (exec_valid_o !== 1'b0 || rs1_data_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL wr_drain got %b/%h exp 0/deadbeef", exec_valid_o, rs1_data_o);
    end
  endtask

  task automatic test_reset_clears_regs();
    reset = 1'b1;
    wb_en_i = 1'b1; wb_addr_i = 5'd5; wb_data_i = 32'h1234_5678;
    tick();
    reset = 1'b0; wb_en_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0002_80B3; fetch_pc_i = 32'h104;
    tick();
    fetch_valid_i = 1'b0;
    checks++;
    if (rs1_data_o !== 32'h0) begin errors++; $display("FAIL rst_clear_x5 got %h exp 0", rs1_data_o); end
    tick();
  endtask

  task automatic test_x0();
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    tick();
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0000_0033; fetch_pc_i = 32'h110;
    tick();
    fetch_valid_i = 1'b0; wb_en_i = 1'b0;
    checks++;
    if (exec_valid_o !== 1'b1 || rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin
      errors++; $display("FAIL x0_operands got v=%b %h/%h exp 1 0/0", exec_valid_o, rs1_data_o, rs2_data_o);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [31:0] pcs [4];
    logic [31:0] ins [4];
    for (int i = 0; i < 4; i++) begin
      pcs[i] = 32'h200 + 32'(i * 4);
      ins[i] = {12'(i + 1), 5'd0, 3'd0, 5'd0, 7'h13};
    end
    exec_ready_i = 1'b1;
    fetch_valid_i = 1'b1; fetch_instr_i = ins[0]; fetch_pc_i = pcs[0];
    tick();
    exec_ready_i = 1'b0;
    fetch_instr_i = ins[1]; fetch_pc_i = pcs[1];
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (fetch_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready c%0d got %b exp 0", c, fetch_ready_o); end
      tick();
      checks++;
      if (exec_valid_o !== 1'b1 || pc_o !== pcs[0] || instr_o !== ins[0]) begin
        errors++; $display("FAIL stall_hold c%0d got v=%b pc=%h in=%h exp 1 %h %h", c, exec_valid_o, pc_o, instr_o, pcs[0], ins[0]);
      end
    end
    exec_ready_i = 1'b1;
    for (int i = 1; i < 4; i++) begin
      fetch_instr_i = ins[i]; fetch_pc_i = pcs[i];
      tick();
      checks++;
      if (exec_valid_o !== 1'b1 || pc_o !== pcs[i] || instr_o !== ins[i]) begin
        errors++; $display("FAIL seq_pc%0d got v=%b pc=%h in=%h exp 1 %h %h", i, exec_valid_o, pc_o, instr_o, pcs[i], ins[i]);
      end
    end
    fetch_valid_i = 1'b0;
    tick();
    checks++;
    if (exec_valid_o !== 1'b0) begin errors++; $display("FAIL seq_drain got %b exp 0", exec_valid_o); end
  endtask

  task automatic test_flush();
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0000_00B3; fetch_pc_i = 32'h300;
    tick();
    exec_ready_i = 1'b0;
    flush_i = 1'b1; fetch_instr_i = 32'h0000_0133; fetch_pc_i = 32'h304;
    wb_en_i = 1'b1; wb_addr_i = 5'd7; wb_data_i = 32'd5;
    tick();
    flush_i = 1'b0; fetch_valid_i = 1'b0; wb_en_i = 1'b0; exec_ready_i = 1'b1;
    checks++;
    if (exec_valid_o !== 1'b0 || instr_o !== 32'h0000_0013) begin
      errors++; $display("FAIL flush_out got v=%b in=%h exp 0 00000013", exec_valid_o, instr_o);
    end
    tick();
    checks++;
    if (exec_valid_o !== 1'b0 || pc_o === 32'h304) begin
      errors++; $display("FAIL flush_dropped got v=%b pc=%h exp 0 not 304", exec_valid_o, pc_o);
    end
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0003_80B3; fetch_pc_i = 32'h308;
    tick();
    fetch_valid_i = 1'b0;
    checks++;
    if (rs1_data_o !== 32'd5) begin errors++; $display("FAIL flush_wb_x7 got %h exp 5", rs1_data_o); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    // Capture with a same-cycle write to the read register.
    wb_en_i = 1'b1; wb_addr_i = 5'd3; wb_data_i = 32'd11;
    tick();
    wb_data_i = 32'd42;
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0001_80B3; fetch_pc_i = 32'h400;
    tick();
    wb_en_i = 1'b0;
    exp = BYPASS ? 32'd42 : 32'd11;
    checks++;
    if (rs1_data_o !== exp) begin errors++; $display("FAIL byp_capture got %0d exp %0d", rs1_data_o, exp); end
    fetch_pc_i = 32'h404;
    tick();
    fetch_valid_i = 1'b0;
    checks++;
    if (rs1_data_o !== 32'd42) begin errors++; $display("FAIL byp_later got %0d exp 42", rs1_data_o); end
    // Stalled hold of rs2=x9 with a write landing during the stall.
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'd3;
    tick();
    wb_en_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_instr_i = 32'h0090_00B3; fetch_pc_i = 32'h408;
    tick();
    fetch_valid_i = 1'b0;
    checks++;
    if (rs2_data_o !== 32'd3) begin errors++; $display("FAIL byp_pre got %0d exp 3", rs2_data_o); end
    exec_ready_i = 1'b0;
    wb_en_i = 1'b1; wb_addr_i = 5'd9; wb_data_i = 32'd7;
    tick();
    wb_en_i = 1'b0;
    exp = BYPASS ? 32'd7 : 32'd3;
    checks++;
    if (rs2_data_o !== exp || rs1_data_o !== 32'd0) begin
      errors++; $display("FAIL byp_stall got %0d/%0d exp 0/%0d", rs1_data_o, rs2_data_o, exp);
    end
    // A write to x0 during the stall never disturbs held operands.
    wb_en_i = 1'b1; wb_addr_i = 5'd0; wb_data_i = 32'hFFFF_FFFF;
    tick();
    wb_en_i = 1'b0;
    checks++;
    if (rs1_data_o !== 32'd0 || rs2_data_o !== exp || exec_valid_o !== 1'b1) begin
      errors++; $display("FAIL byp_x0_stall got v=%b %h/%h exp 1 0/%h", exec_valid_o, rs1_data_o, rs2_data_o, exp);
    end
    exec_ready_i = 1'b1;
    tick();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_reset_clears_regs();
    test_x0();
    test_stall();
    test_flush();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_decode.md
Name: cpu_decode

Overview:
Decode/register-read stage directly upstream of the execute stage.
- Holds the 32x32 integer register file.
- Accepts instructions from fetch over a valid/ready handshake.
- Reads rs1/rs2 and presents instruction, PC and operands to execute through a one-entry pipeline register.
- Takes the writeback write port and keeps held operands coherent with writes that land while execute is stalled.

Parameters:
- RESET_PC, 32'h0000_0000, value of pc_o after reset.
- NOP_INSTR, 32'h0000_0013, value of instr_o after reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  fetch presents an instruction.
- fetch_ready_o  out  1  stage can accept this cycle.
- fetch_instr_i  in  32  instruction word.
- fetch_pc_i  in  32  PC of the instruction.
- flush_i  in  1  discard the held and the incoming instruction.
- wb_en_i  in  1  writeback write enable.
- wb_addr_i  in  5  writeback destination register.
- wb_data_i  in  32  writeback data.
- exec_valid_o  out  1  output register holds a valid instruction.
- exec_ready_i  in  1  execute consumes the held instruction this cycle.
- instr_o  out  32  held instruction (drives execute instr_i).
- pc_o  out  32  held PC.
- rs1_data_o  out  32  operand for instr_o[19:15] (drives execute rs1_data_i).
- rs2_data_o  out  32  operand for instr_o[24:20] (drives execute rs2_data_i).

Behaviour:
Reset (reset=1 at an edge):
- exec_valid_o=0, instr_o=NOP_INSTR, pc_o=RESET_PC, rs1_data_o=rs2_data_o=0.
- All 32 registers cleared to 0.
- Reset overrides flush, capture and writeback in the same cycle.

Register file:
- x0 reads 0 always; writes to x0 are ignored.
- Write at the edge when wb_en_i=1 and wb_addr_i!=0.
- Read is combinational from the current contents, with bypass per the optional feature.

Handshake:
- fetch_ready_o = !exec_valid_o || exec_ready_i, combinational; deasserted while reset=1.
- Capture occurs when fetch_valid_i && fetch_ready_o && !flush_i. At the next edge:
  - exec_valid_o=1;
  - instr_o, pc_o load from fetch;
  - rs1_data_o/rs2_data_o load the register-file read of fetch_instr_i[19:15]/[24:20].
- Fields are read regardless of instruction format; deciding whether an operand is used belongs to execute.
- If exec_ready_i=1 and there is no capture, exec_valid_o clears and the data outputs hold their values.
- If exec_valid_o=1 and exec_ready_i=0, all outputs hold (stall).
- Latency: 1 cycle from fetch accept to exec_valid_o. Throughput: 1 instruction/cycle with no bubbles when exec_ready_i=1.

Flush:
- flush_i=1 at an edge sets exec_valid_o=0 and instr_o=NOP_INSTR.
- The incoming instruction is dropped even when fetch_valid_i=1.
- A writeback in the same cycle still commits.
- Flush has priority over capture and stall.

Simultaneous events:
- A capture and a writeback in the same cycle both occur. Whether the captured operand sees the new value is set by the optional feature.
- A writeback to x0 never alters any operand.

Optional Feature:
CPU_DECODE_BYPASS_EN

Defined:
- Capture bypass: if wb_en_i && wb_addr_i!=0 && wb_addr_i equals a read field, the captured operand is wb_data_i.
- Stall refresh: while exec_valid_o=1 and exec_ready_i=0, a writeback with wb_addr_i equal to instr_o[19:15] (or [24:20], nonzero) updates rs1_data_o (or rs2_data_o) with wb_data_i at that edge. When both fields match, both update.

Undefined:
- A read returns the pre-write value, so a write becomes visible one cycle later.
- Held operands never change during a stall.
- The hazard unit must stall to cover this.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles -> exec_valid_o=0, instr_o=32'h13, pc_o=0, rs1/rs2 data 0, fetch_ready_o=0 during reset and 1 after.
2. Write then read: wb x5=32'hDEAD_BEEF at cycle N; capture add x1,x5,x0 (32'h000280B3) at N+1 with pc 32'h100 -> next cycle exec_valid_o=1, rs1_data_o=32'hDEADBEEF, rs2_data_o=0, pc_o=32'h100.
3. x0 protection: wb x0=32'hFFFF_FFFF, then capture an instruction reading x0 -> both operands 0.
4. Stall/backpressure: hold exec_ready_i=0 for 3 cycles with fetch_valid_i=1 -> fetch_ready_o=0 and outputs stable. Raise exec_ready_i -> the next fetch instruction appears one cycle later with no loss or duplication (check a sequence of 4 PCs).
5. Flush: exec_valid_o=1, and flush_i=1 with fetch_valid_i=1 in the same cycle -> next cycle exec_valid_o=0, instr_o=32'h13, the fetch instruction is never presented, and a simultaneous wb x7=5 is visible later.
6. Bypass (both builds):
   - Capture reading x3 in the same cycle as wb x3=42 -> rs1_data_o=42 with CPU_DECODE_BYPASS_EN, the old value without it.
   - Stalled hold of rs2=x9 with wb x9=7 -> rs2_data_o becomes 7 with the macro, unchanged without it.
